// File: rtl/addsub_pkg.sv
// Shared constants and FSM encoding for the nibble-serial adder/subtractor.
package addsub_pkg;

   localparam int unsigned DefaultWidth = 16;
   localparam int unsigned SliceW       = 4;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StBusy = 2'd1,
      StDone = 2'd2
   } state_e;

endpackage

// File: rtl/adder4_slice.sv
// Combinational 4-bit adder slice; also exposes the carry into its MSB.
module adder4_slice
   import addsub_pkg::*;
(
   input  logic [SliceW-1:0] a,
   input  logic [SliceW-1:0] b,
   input  logic              cin,
   output logic [SliceW-1:0] sum,
   output logic              cout,
   output logic              c3
);

   logic [SliceW-1:0] low;
   logic [1:0]        high;

   // Split at the MSB so the carry into it is available for overflow detection.
   assign low  = {1'b0, a[SliceW-2:0]} + {1'b0, b[SliceW-2:0]} + {{(SliceW-1){1'b0}}, cin};
   assign c3   = low[SliceW-1];
   assign high = {1'b0, a[SliceW-1]} + {1'b0, b[SliceW-1]} + {1'b0, c3};
   assign sum  = {high[0], low[SliceW-2:0]};
   assign cout = high[1];

endmodule

// File: rtl/nibble_serial_addsub.sv
// Nibble-serial two's-complement adder/subtractor with valid/ready handshakes.
module nibble_serial_addsub
   import addsub_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow
);

   localparam int unsigned     NumSlices = WIDTH / SliceW;
   localparam int unsigned     CntW      = (NumSlices > 1) ? $clog2(NumSlices) : 1;
   localparam logic [CntW-1:0] LastCnt   = CntW'(NumSlices - 1);

   state_e            state_q, state_d;
   logic              live_q;
   logic [WIDTH-1:0]  a_q, b_q, sum_q;
   logic [CntW-1:0]   cnt_q;
   logic              carry_q, carry_out_q, overflow_q;
   logic              accept, slice_last;
   logic [SliceW-1:0] slice_a, slice_b, slice_sum;
   logic              slice_cout, slice_c3;

   // live_q keeps in_ready low while reset is held and sets on the first edge after release.
   assign accept     = (state_q == StIdle) && live_q && in_valid;
   assign slice_last = (cnt_q == LastCnt);
   assign slice_a    = a_q[cnt_q*SliceW +: SliceW];
   assign slice_b    = b_q[cnt_q*SliceW +: SliceW];

   adder4_slice u_slice (
      .a    (slice_a),
      .b    (slice_b),
      .cin  (carry_q),
      .sum  (slice_sum),
      .cout (slice_cout),
      .c3   (slice_c3)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         live_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         live_q  <= 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (accept) state_d = StBusy;
         StBusy:  if (slice_last) state_d = StDone;
         StDone:  if (out_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         carry_out_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else if (accept) begin
         // Subtraction is a + ~b + 1: invert b here and seed the carry with mode.
         a_q     <= a;
         b_q     <= b ^ {WIDTH{mode}};
         carry_q <= mode;
         cnt_q   <= '0;
      end else if (state_q == StBusy) begin
         sum_q[cnt_q*SliceW +: SliceW] <= slice_sum;
         carry_q                       <= slice_cout;
         cnt_q                         <= cnt_q + CntW'(1);
         if (slice_last) begin
            carry_out_q <= slice_cout;
            overflow_q  <= slice_cout ^ slice_c3;
         end
      end
   end

   assign in_ready  = (state_q == StIdle) && live_q;
   assign out_valid = (state_q == StDone);
   assign sum       = sum_q;
   assign carry_out = carry_out_q;
   assign overflow  = overflow_q;

endmodule
